fb_mem_responder: RTL
=====================

FB_MEM_RESPONDER -- requirements
Module: fb_mem_responder

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 6, word address width.
REQ-002 Parameter DATA_WIDTH, default 10, word width.
REQ-003 Parameter DEPTH, default 64, number of words (2**ADDRESS_WIDTH).
REQ-004 Parameter IO_ADDR, default 63, address of the memory-mapped output port.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 i_we  input  1  CPU write enable.
REQ-008 i_addr  input  ADDRESS_WIDTH  CPU word address (MAR).
REQ-009 i_ram_data_in  input  DATA_WIDTH  CPU write data (MDRIn).
REQ-010 o_ram_data_out  output  DATA_WIDTH  registered read data to CPU (MDROut).
REQ-011 i_ld_valid  input  1  loader word valid.
REQ-012 o_ld_ready  output  1  loader may transfer this cycle.
REQ-013 i_ld_addr  input  ADDRESS_WIDTH  loader word address.
REQ-014 i_ld_data  input  DATA_WIDTH  loader word data.
REQ-015 i_ld_done  input  1  single-cycle pulse ending the load phase.
REQ-016 o_run  output  1  high while CPU accesses are served.
REQ-017 o_io_data  output  DATA_WIDTH  last value the CPU wrote to IO_ADDR.
REQ-018 o_io_strobe  output  1  one-cycle pulse per CPU write to IO_ADDR.
REQ-019 o_wr_count  output  16  count of CPU writes accepted in RUN, saturating.

Function
REQ-020 FSM states: CLEAR, LOAD, RUN; reset entry state is CLEAR.
REQ-021 CLEAR: one word zeroed per cycle, addresses 0..DEPTH-1 ascending; after address DEPTH-1 is written, next state LOAD (DEPTH cycles total).
REQ-022 LOAD: o_ld_ready=1; a transfer occurs when i_ld_valid & o_ld_ready on a rising edge, writing i_ld_data to memory[i_ld_addr].
REQ-023 LOAD: i_ld_done=1 moves to RUN next cycle; a transfer in that same cycle still completes.
REQ-024 o_ld_ready=0 in CLEAR and RUN; i_ld_valid outside LOAD is ignored, with no memory change.
REQ-025 RUN: o_run=1; state held until reset, and i_ld_done is ignored.
REQ-026 RUN read: o_ram_data_out <= memory[i_addr] every rising edge (1-cycle latency, address sampled at the edge).
REQ-027 RUN write: i_we=1 writes i_ram_data_in to memory[i_addr] at the edge.
REQ-028 Simultaneous read/write to same address: read-first, so o_ram_data_out shows the old word and the new word is visible the next cycle.
REQ-029 RUN write with i_addr==IO_ADDR: memory is also written, o_io_data <= i_ram_data_in, o_io_strobe=1 for exactly the following cycle.
REQ-030 Back-to-back IO_ADDR writes: o_io_strobe stays high each cycle and o_io_data updates each cycle.
REQ-031 o_wr_count increments by 1 per RUN write (including IO_ADDR) and holds at 16'hFFFF.
REQ-032 CLEAR/LOAD: i_we ignored, o_ram_data_out held 0, o_io_strobe 0, o_wr_count unchanged.
REQ-033 Addresses >= DEPTH (only when DEPTH < 2**ADDRESS_WIDTH): writes dropped, reads return 0.

Reset
REQ-034 rst=0 asynchronously forces state CLEAR with the clear address at 0, and sets o_ram_data_out=0, o_ld_ready=0, o_run=0, o_io_data=0, o_io_strobe=0, o_wr_count=0.
REQ-035 Memory contents are not reset directly; the CLEAR phase after reset release zeroes them.
REQ-036 Reset asserted mid-CLEAR, mid-LOAD or in RUN aborts the operation; after release the full CLEAR sequence restarts from address 0.

Verification
REQ-037 Release reset, hold loader idle -> o_ld_ready rises exactly 64 cycles after release; every memory word is 0.
REQ-038 LOAD writes (5,10'd15), (6,10'd50) then pulse i_ld_done -> o_run=1 next cycle; RUN read addr 5 returns 15 and addr 6 returns 50 one cycle after address presentation.
REQ-039 RUN write 10'd50 to addr 52 with a same-cycle read of addr 52 (prior value 0) -> o_ram_data_out=0 that cycle, 50 the next cycle; o_wr_count=1.
REQ-040 RUN write 10'd7 then 10'd9 to addr 63 on consecutive cycles -> o_io_strobe high 2 cycles, o_io_data 7 then 9, memory[63]=9, o_wr_count=2.
REQ-041 i_we=1, addr 3, data 10'd99 during LOAD -> memory[3] unchanged, o_wr_count=0.
REQ-042 Assert rst in RUN after 0x10000 writes -> o_wr_count reads 16'hFFFF before reset, 0 during reset; o_run drops immediately; CLEAR restarts and memory[52]=0 after 64 cycles.

Source files
------------

// File: rtl/fb_mem_responder.sv
// Purpose : word memory behind a CLEAR -> LOAD -> RUN sequencer, with one memory-mapped output port.
// Latency : CPU reads return one cycle after the address edge (read-first); loader and CPU writes land at the edge.
// Backpressure: the loader is only accepted in LOAD (o_ld_ready); CPU accesses are never stalled but only served in RUN.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   i_we, i_addr,
//   i_ram_data_in             CPU write enable / word address / write data
//   o_ram_data_out            registered CPU read data (0 outside RUN)
//   i_ld_valid, o_ld_ready,
//   i_ld_addr, i_ld_data      loader word handshake
//   i_ld_done                 pulse that ends LOAD
//   o_run                     high while CPU accesses are served
//   o_io_data, o_io_strobe    last CPU write to IO_ADDR and its one-cycle pulse
//   o_wr_count                saturating count of CPU writes accepted in RUN
module fb_mem_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 64,
  parameter int IO_ADDR       = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_in,
  output logic [DATA_WIDTH-1:0]    o_ram_data_out,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0]    i_ld_data,
  input  logic                     i_ld_done,
  output logic                     o_run,
  output logic [DATA_WIDTH-1:0]    o_io_data,
  output logic                     o_io_strobe,
  output logic [15:0]              o_wr_count
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] IO_ADDR_W = ADDRESS_WIDTH'(IO_ADDR);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clrAddr;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     cpuInRange;
  logic                     ldInRange;
  logic                     memWe;
  logic [ADDRESS_WIDTH-1:0] memWaddr;
  logic [DATA_WIDTH-1:0]    memWdata;

  // Range checks only exist when the address space is larger than the array;
  // otherwise every address is backed by a word.
  generate
    if (DEPTH < (1 << ADDRESS_WIDTH)) begin : gPartial
      assign cpuInRange = (int'(i_addr) < DEPTH);
      assign ldInRange  = (int'(i_ld_addr) < DEPTH);
    end else begin : gFull
      assign cpuInRange = 1'b1;
      assign ldInRange  = 1'b1;
    end
  endgenerate

  // Single write port shared by the three phases; the phase decides who owns it.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = clrAddr;
    memWdata = '0;
    case (state)
      CLEAR: memWe = 1'b1;
      LOAD: begin
        if (i_ld_valid && o_ld_ready && ldInRange) begin
          memWe    = 1'b1;
          memWaddr = i_ld_addr;
          memWdata = i_ld_data;
        end
      end
      RUN: begin
        if (i_we && cpuInRange) begin
          memWe    = 1'b1;
          memWaddr = i_addr;
          memWdata = i_ram_data_in;
        end
      end
      default: ;
    endcase
  end

  // Storage has no reset; the CLEAR phase is what zeroes it.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= CLEAR;
      clrAddr        <= '0;
      o_ram_data_out <= '0;
      o_ld_ready     <= 1'b0;
      o_run          <= 1'b0;
      o_io_data      <= '0;
      o_io_strobe    <= 1'b0;
      o_wr_count     <= '0;
    end else begin
      o_io_strobe <= 1'b0;
      case (state)
        CLEAR: begin
          clrAddr <= clrAddr + ADDRESS_WIDTH'(1);
          if (clrAddr == LAST_ADDR) begin
            state      <= LOAD;
            clrAddr    <= '0;
            o_ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          // A transfer in the done cycle still lands because o_ld_ready is
          // still high for that edge.
          if (i_ld_done) begin
            state      <= RUN;
            o_ld_ready <= 1'b0;
            o_run      <= 1'b1;
          end
        end
        RUN: begin
          // Non-blocking read of mem gives read-first on a same-address write.
          o_ram_data_out <= cpuInRange ? mem[i_addr] : '0;
          if (i_we) begin
            if (o_wr_count != 16'hFFFF) begin
              o_wr_count <= o_wr_count + 16'd1;
            end
            if (i_addr == IO_ADDR_W) begin
              o_io_data   <= i_ram_data_in;
              o_io_strobe <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
